mul_operand_sequencer: RTL

Parametrised operand selector and sequencer for the vALU multiplier array. It accepts one vector operand pair per handshake, slices it by SEW into 8- or 16-bit chunks, and sign- or zero-extends each chunk to multiplier width. It drives NUM_MULT small signed multipliers with the partial-product operands. SEW=64 elements need twice the multiplier capacity, so they are issued over two beats with valid/ready backpressure on both sides.

---
 rtl/mul_operand_sequencer_if.sv | 37 +++
 rtl/mul_operand_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mul_operand_sequencer_if.sv
// Operand-pair request and multiplier-beat response bundle for mul_operand_sequencer.
// master drives requests and beat ready; slave is the sequencer.
interface mul_operand_sequencer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int MULT_W     = 18,
  parameter int TAG_W      = 4
);
  localparam int NUM_MULT = DATA_WIDTH / 8;

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      in_vec0;
  logic [DATA_WIDTH-1:0]      in_vec1;
  logic [1:0]                 in_opsel;
  logic [1:0]                 in_sew;
  logic [TAG_W-1:0]           in_tag;

  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_MULT*MULT_W-1:0] out_a;
  logic [NUM_MULT*MULT_W-1:0] out_b;
  logic                       out_beat;
  logic                       out_last;
  logic [1:0]                 out_sew;
  logic [1:0]                 out_opsel;
  logic [TAG_W-1:0]           out_tag;

  modport master (
    output in_valid, in_vec0, in_vec1, in_opsel, in_sew, in_tag, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_beat, out_last, out_sew, out_opsel, out_tag
  );

  modport slave (
    input  in_valid, in_vec0, in_vec1, in_opsel, in_sew, in_tag, out_ready,
    output in_ready, out_valid, out_a, out_b, out_beat, out_last, out_sew, out_opsel, out_tag
  );
endinterface

// File: rtl/mul_operand_sequencer.sv
// Slices operand pairs by SEW into extended multiplier operands; 1-cycle latency, SEW64 in two beats.
// Output register stalls on !out_ready; input accepted only in IDLE with a free or draining output.
module mul_operand_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int MULT_W     = 18,
  parameter int TAG_W      = 4
) (
  input logic                   clk,
  input logic                   rst,
  mul_operand_sequencer_if.slave bus
);
  localparam int NUM_MULT = DATA_WIDTH / 8;
  localparam int NUM_H    = DATA_WIDTH / 16;
  localparam int NUM_E32  = DATA_WIDTH / 32;
  localparam int NUM_E64  = DATA_WIDTH / 64;
  localparam int OUT_W    = NUM_MULT * MULT_W;

  typedef enum logic {IDLE, SECOND} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] hold_vec0_q;
  logic [DATA_WIDTH-1:0] hold_vec1_q;
  logic                  out_valid_q;
  logic [OUT_W-1:0]      out_a_q;
  logic [OUT_W-1:0]      out_b_q;
  logic                  out_beat_q;
  logic                  out_last_q;
  logic [1:0]            out_sew_q;
  logic [1:0]            out_opsel_q;
  logic [TAG_W-1:0]      out_tag_q;

  logic                  load;
  logic                  sel_second;
  logic [DATA_WIDTH-1:0] src_vec0;
  logic [DATA_WIDTH-1:0] src_vec1;
  logic [1:0]            src_opsel;
  logic [1:0]            src_sew;
  logic                  a_s;
  logic                  b_s;
  logic [OUT_W-1:0]      mult_a_d;
  logic [OUT_W-1:0]      mult_b_d;

  function automatic logic [MULT_W-1:0] ext_h(input logic [15:0] h, input logic sx);
    return {{(MULT_W-16){sx & h[15]}}, h};
  endfunction

  function automatic logic [MULT_W-1:0] ext_b(input logic [7:0] b, input logic sx);
    return {{(MULT_W-8){sx & b[7]}}, b};
  endfunction

  assign load       = !out_valid_q | bus.out_ready;
  assign sel_second = (state_q == SECOND);

  // Beat 1 of a SEW64 element is rebuilt from held operands; opsel lives on in out_opsel_q.
  assign src_vec0  = sel_second ? hold_vec0_q : bus.in_vec0;
  assign src_vec1  = sel_second ? hold_vec1_q : bus.in_vec1;
  assign src_opsel = sel_second ? out_opsel_q : bus.in_opsel;
  assign src_sew   = sel_second ? 2'b11 : bus.in_sew;
  assign a_s       = (src_opsel != 2'b00);
  assign b_s       = src_opsel[0];

  always_comb begin
    mult_a_d = '0;
    mult_b_d = '0;
    case (src_sew)
      2'b00: begin
        for (int k = 0; k < NUM_MULT; k++) begin
          mult_a_d[k*MULT_W +: MULT_W] = ext_b(src_vec0[8*k +: 8], a_s);
          mult_b_d[k*MULT_W +: MULT_W] = ext_b(src_vec1[8*k +: 8], b_s);
        end
      end
      2'b01: begin
        for (int k = 0; k < NUM_H; k++) begin
          mult_a_d[k*MULT_W +: MULT_W] = ext_h(src_vec0[16*k +: 16], a_s);
          mult_b_d[k*MULT_W +: MULT_W] = ext_h(src_vec1[16*k +: 16], b_s);
        end
      end
      2'b10: begin
        for (int e = 0; e < NUM_E32; e++) begin
          for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
              mult_a_d[(4*e+2*i+j)*MULT_W +: MULT_W] = ext_h(src_vec0[16*(2*e+i) +: 16], a_s & (i == 1));
              mult_b_d[(4*e+2*i+j)*MULT_W +: MULT_W] = ext_h(src_vec1[16*(2*e+j) +: 16], b_s & (j == 1));
            end
          end
        end
      end
      default: begin
        // b half index j = 2*beat + jj; only half 3 is an element's top half.
        for (int e = 0; e < NUM_E64; e++) begin
          for (int i = 0; i < 4; i++) begin
            for (int jj = 0; jj < 2; jj++) begin
              mult_a_d[(8*e+2*i+jj)*MULT_W +: MULT_W] =
                ext_h(src_vec0[16*(4*e+i) +: 16], a_s & (i == 3));
              mult_b_d[(8*e+2*i+jj)*MULT_W +: MULT_W] =
                ext_h(src_vec1[16*(4*e+2*int'(sel_second)+jj) +: 16],
                      b_s & ((2*int'(sel_second)+jj) == 3));
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_vec0_q <= '0;
      hold_vec1_q <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_beat_q  <= 1'b0;
      out_last_q  <= 1'b0;
      out_sew_q   <= 2'b00;
      out_opsel_q <= 2'b00;
      out_tag_q   <= '0;
    end else if (load) begin
      if (state_q == SECOND) begin
        out_valid_q <= 1'b1;
        out_a_q     <= mult_a_d;
        out_b_q     <= mult_b_d;
        out_beat_q  <= 1'b1;
        out_last_q  <= 1'b1;
        state_q     <= IDLE;
      end else if (bus.in_valid) begin
        out_valid_q <= 1'b1;
        out_a_q     <= mult_a_d;
        out_b_q     <= mult_b_d;
        out_beat_q  <= 1'b0;
        out_last_q  <= (bus.in_sew != 2'b11);
        out_sew_q   <= bus.in_sew;
        out_opsel_q <= bus.in_opsel;
        out_tag_q   <= bus.in_tag;
        if (bus.in_sew == 2'b11) begin
          state_q     <= SECOND;
          hold_vec0_q <= bus.in_vec0;
          hold_vec1_q <= bus.in_vec1;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_beat  = out_beat_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sew   = out_sew_q;
  assign bus.out_opsel = out_opsel_q;
  assign bus.out_tag   = out_tag_q;
endmodule
